cnn_frame_sequencer: RTL and testbench

- Frame-level controller in front of the 2-kernel conv/ReLU/pool pipeline.
- On `start` it latches and validates the frame configuration, then streams the pixels from an external pixel memory (1-cycle read latency) into the pipeline as a valid-qualified stream.
- It counts pooled outputs on the 2-bit pool valid bus and raises `done` when the expected count is reached.
- It flags configuration errors, kernel-lane mismatches and drain timeouts.

---
 rtl/cnn_pkg.sv | 23 ++
 rtl/cnn_frame_sequencer_if.sv | 27 ++
 rtl/pix_fetch.sv | 42 ++++
 rtl/cnn_frame_sequencer.sv | 143 ++++++++++++++
 tb/tb_cnn_frame_sequencer.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_pkg.sv
// Shared constants for the CNN frame sequencer: padding modes, error codes and
// the FSM state encoding.
package cnn_pkg;

  localparam logic [1:0] PAD_NONE    = 2'b00;
  localparam logic [1:0] PAD_ZERO    = 2'b01;
  localparam logic [1:0] PAD_EDGE    = 2'b10;
  localparam logic [1:0] PAD_ILLEGAL = 2'b11;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_CFG     = 2'b01;
  localparam logic [1:0] ERR_LANE    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_CHECK  = 3'd1;
  localparam state_t ST_STREAM = 3'd2;
  localparam state_t ST_DRAIN  = 3'd3;
  localparam state_t ST_FINISH = 3'd4;

endpackage

// File: rtl/cnn_frame_sequencer_if.sv
// Pixel-memory port, pixel stream to the pipeline and pooled-output feedback,
// bundled so the sequencer and its environment connect through one port.
interface cnn_frame_sequencer_if #(
   parameter int PIX_W  = 16,
   parameter int ADDR_W = 16
);
   // Handshake: pix_valid is a one-cycle strobe with no ready. Backpressure is
   // stall, which only blocks issuing new reads; a read already issued always
   // yields pix_valid exactly one cycle later. pool_valid is likewise a strobe.
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [PIX_W-1:0]  mem_rd_data;
   logic              pix_valid;
   logic [PIX_W-1:0]  pix_data;
   logic              stall;
   logic [1:0]        pool_valid;

   modport master (
      output mem_rd_en, mem_addr, pix_valid, pix_data,
      input  mem_rd_data, stall, pool_valid
   );

   modport slave (
      input  mem_rd_en, mem_addr, pix_valid, pix_data,
      output mem_rd_data, stall, pool_valid
   );
endinterface

// File: rtl/pix_fetch.sv
// Raster address counter for the pixel memory plus alignment of the returned
// data with its valid strobe.
module pix_fetch #(
   parameter int PIX_W  = 16,
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              active,
   input  logic              stall,
   input  logic [15:0]       total,
   input  logic [PIX_W-1:0]  rd_data,
   output logic              rd_en,
   output logic [ADDR_W-1:0] addr,
   output logic              last_rd,
   output logic              pix_valid,
   output logic [PIX_W-1:0]  pix_data
);
   logic [ADDR_W-1:0] rd_addr;
   logic [ADDR_W-1:0] total_ext;

   assign total_ext = ADDR_W'(total);
   assign rd_en     = active && !stall && (rd_addr < total_ext);
   assign last_rd   = rd_en && (rd_addr == total_ext - ADDR_W'(1));
   assign addr      = rd_en ? rd_addr : '0;
   // Memory data is already registered on its side, so it lines up with pix_valid.
   assign pix_data  = pix_valid ? rd_data : '0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_addr   <= '0;
         pix_valid <= 1'b0;
      end else begin
         pix_valid <= rd_en;
         if (clear)
            rd_addr <= '0;
         else if (rd_en)
            rd_addr <= rd_addr + ADDR_W'(1);
      end
   end
endmodule

// File: rtl/cnn_frame_sequencer.sv
// Frame controller for the 2-kernel conv/ReLU/pool pipeline: validates the
// frame config, streams pixels from memory and counts pooled outputs.
module cnn_frame_sequencer
   import cnn_pkg::*;
#(
   parameter int PIX_W         = 16,
   parameter int ADDR_W        = 16,
   parameter int DRAIN_TIMEOUT = 1024
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [7:0]            cfg_width,
   input  logic [7:0]            cfg_height,
   input  logic [1:0]            cfg_padding,
   cnn_frame_sequencer_if.master bus,
   output logic [7:0]            img_width,
   output logic [7:0]            img_height,
   output logic [1:0]            padding_mode,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [1:0]            err_code,
   output logic [15:0]           out_count,
   output state_t                dbg_state
);
   localparam int IDLE_W = $clog2(DRAIN_TIMEOUT + 1);

   state_t            state;
   logic [7:0]        wc, hc, wm, hm;
   logic              cfg_bad;
   logic [15:0]       exp_cnt, frame_pix, cnt_next;
   logic              cnt_en, lane0, lane_err;
   logic              rd_en, last_rd, pix_valid;
   logic [ADDR_W-1:0] rd_addr;
   logic [PIX_W-1:0]  pix_data;
   logic [IDLE_W-1:0] idle_cnt, idle_next;

   // Unpadded convolution shrinks each side by 2; the 5/3 minimums keep Wc/Hc >= 3.
   always_comb begin
      wc      = img_width;
      hc      = img_height;
      cfg_bad = 1'b0;
      if (padding_mode == PAD_NONE) begin
         wc      = img_width - 8'd2;
         hc      = img_height - 8'd2;
         cfg_bad = (img_width < 8'd5) || (img_height < 8'd5);
      end else begin
         cfg_bad = (padding_mode == PAD_ILLEGAL) || (img_width < 8'd3) || (img_height < 8'd3);
      end
      wm      = wc - 8'd2;
      hm      = hc - 8'd2;
      exp_cnt = {8'd0, wm} * {8'd0, hm};
   end

   assign frame_pix = {8'd0, img_width} * {8'd0, img_height};
   assign cnt_en    = (state == ST_STREAM) || (state == ST_DRAIN);
   assign lane0     = cnt_en && bus.pool_valid[0];
   assign lane_err  = cnt_en && (bus.pool_valid[0] != bus.pool_valid[1]);
   assign cnt_next  = (lane0 && out_count != 16'hFFFF) ? out_count + 16'd1 : out_count;
   assign idle_next = idle_cnt + IDLE_W'(1);

   assign busy      = (state != ST_IDLE);
   assign done      = (state == ST_FINISH);
   assign dbg_state = state;

   assign bus.mem_rd_en = rd_en;
   assign bus.mem_addr  = rd_addr;
   assign bus.pix_valid = pix_valid;
   assign bus.pix_data  = pix_data;

   pix_fetch #(.PIX_W(PIX_W), .ADDR_W(ADDR_W)) u_fetch (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (state == ST_CHECK),
      .active    (state == ST_STREAM),
      .stall     (bus.stall),
      .total     (frame_pix),
      .rd_data   (bus.mem_rd_data),
      .rd_en     (rd_en),
      .addr      (rd_addr),
      .last_rd   (last_rd),
      .pix_valid (pix_valid),
      .pix_data  (pix_data)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         img_width    <= '0;
         img_height   <= '0;
         padding_mode <= '0;
         err          <= 1'b0;
         err_code     <= ERR_OK;
         out_count    <= '0;
         idle_cnt     <= '0;
      end else begin
         if (cnt_en)
            out_count <= cnt_next;
         if (lane_err) begin
            err      <= 1'b1;
            err_code <= ERR_LANE;
         end
         case (state)
            ST_IDLE: if (start) begin
               img_width    <= cfg_width;
               img_height   <= cfg_height;
               padding_mode <= cfg_padding;
               err          <= 1'b0;
               err_code     <= ERR_OK;
               out_count    <= '0;
               state        <= ST_CHECK;
            end
            ST_CHECK: if (cfg_bad) begin
               err      <= 1'b1;
               err_code <= ERR_CFG;
               state    <= ST_FINISH;
            end else begin
               state <= ST_STREAM;
            end
            ST_STREAM: begin
               idle_cnt <= '0;
               if (last_rd)
                  state <= ST_DRAIN;
            end
            // >= so an overshoot during STREAM still exits on DRAIN entry.
            ST_DRAIN: if (cnt_next >= exp_cnt) begin
               state <= ST_FINISH;
            end else if (lane0) begin
               idle_cnt <= '0;
            end else if (idle_next == IDLE_W'(DRAIN_TIMEOUT)) begin
               err      <= 1'b1;
               err_code <= ERR_TIMEOUT;
               state    <= ST_FINISH;
            end else begin
               idle_cnt <= idle_next;
            end
            ST_FINISH: state <= ST_IDLE;
            default:   state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Scoreboard bench for cnn_frame_sequencer: directed frames, a memory model and
// a hand-driven pool-valid model; a monitor checks pixels and frame results.
module tb_cnn_frame_sequencer;
   import cnn_pkg::*;

   localparam int PIX_W = 16;
   localparam int ADDR_W = 16;
   localparam int TO = 1024;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] cfg_width = '0;
   logic [7:0] cfg_height = '0;
   logic [1:0] cfg_padding = '0;
   logic [7:0] img_width, img_height;
   logic [1:0] padding_mode, err_code;
   logic       busy, done, err;
   logic [15:0] out_count;
   state_t     dbg_state;

   cnn_frame_sequencer_if #(.PIX_W(PIX_W), .ADDR_W(ADDR_W)) bus ();

   cnn_frame_sequencer #(.PIX_W(PIX_W), .ADDR_W(ADDR_W), .DRAIN_TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_padding(cfg_padding),
      .bus(bus),
      .img_width(img_width), .img_height(img_height), .padding_mode(padding_mode),
      .busy(busy), .done(done), .err(err), .err_code(err_code),
      .out_count(out_count), .dbg_state(dbg_state)
   );

   // ---------------- clock / reset / cycle counter ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   logic [15:0] exp_q[$];
   logic [18:0] res_q[$];
   int n_checks = 0;
   int n_pass = 0;

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endfunction

   function automatic logic [15:0] pix_of(input logic [15:0] a);
      return a ^ 16'hA55A;
   endfunction

   // Memory model: one-cycle read latency.
   int rd_cnt = 0;
   always @(posedge clk) begin
      if (bus.mem_rd_en) begin
         bus.mem_rd_data <= pix_of(bus.mem_addr);
         rd_cnt <= rd_cnt + 1;
      end
   end

   // Monitor: pops expected pixels and frame results as the DUT presents them.
   int pix_seen = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   logic [15:0] mon_exp;
   always @(posedge clk) begin
      #1;
      if (bus.pix_valid === 1'b1) begin
         pix_seen++;
         if (exp_q.size() == 0) check("pix_unexpected", 1, 0);
         else begin
            mon_exp = exp_q.pop_front();
            check("pix_data", bus.pix_data, mon_exp);
         end
      end
      if (done === 1'b1) begin
         done_cnt++;
         done_cyc = cyc;
         if (res_q.size() == 0) check("done_unexpected", 1, 0);
         else check("frame_result", {err, err_code, out_count}, res_q.pop_front());
      end
   end

   // ---------------- driver tasks ----------------
   int start_cyc = 0;
   int last_pulse_cyc = 0;

   task automatic check_reset_outputs(input string tag);
      check({tag, "_status"}, {busy, done, err, err_code, out_count, img_width, img_height,
                               padding_mode, dbg_state}, '0);
      check({tag, "_bus"}, {bus.mem_rd_en, bus.mem_addr, bus.pix_valid, bus.pix_data}, '0);
   endtask

   task automatic start_frame(input logic [7:0] w, input logic [7:0] h, input logic [1:0] pad);
      @(negedge clk);
      cfg_width = w; cfg_height = h; cfg_padding = pad;
      start = 1'b1;
      start_cyc = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_pixels(input int target, input int stall_at, input int poke_at, input int budget);
      int t = 0;
      while (pix_seen < target && t < budget) begin
         @(negedge clk);
         t++;
         if (t == stall_at) bus.stall = 1'b1;
         if (t == stall_at + 3) bus.stall = 1'b0;
         if (t == poke_at) begin start = 1'b1; cfg_width = 8'hEE; cfg_padding = PAD_ILLEGAL; end
         if (t == poke_at + 1) start = 1'b0;
      end
      bus.stall = 1'b0;
      start = 1'b0;
      check("pixels_delivered", pix_seen, target);
   endtask

   task automatic emit_pulses(input int n, input int drop_idx);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus.pool_valid = (i == drop_idx) ? 2'b01 : 2'b11;
         last_pulse_cyc = cyc;
         @(negedge clk);
         bus.pool_valid = 2'b00;
      end
   endtask

   task automatic wait_done(input int d0, input int budget);
      int t = 0;
      while (done_cnt == d0 && t < budget) begin
         @(negedge clk);
         t++;
      end
      check("done_seen", done_cnt, d0 + 1);
   endtask

   task automatic run_frame(input logic [7:0] w, input logic [7:0] h, input logic [1:0] pad,
                            input bit bad, input int n_pulse, input int drop_idx,
                            input int stall_at, input int poke_at,
                            input logic [18:0] exp_res, input int exp_gap);
      int p0, r0, d0, npix;
      npix = bad ? 0 : int'(w) * int'(h);
      for (int i = 0; i < npix; i++) exp_q.push_back(pix_of(16'(i)));
      res_q.push_back(exp_res);
      p0 = pix_seen; r0 = rd_cnt; d0 = done_cnt;
      start_frame(w, h, pad);
      if (!bad) begin
         wait_pixels(p0 + npix, stall_at, poke_at, 4 * npix + 20);
         emit_pulses(n_pulse, drop_idx);
      end
      wait_done(d0, TO + 200);
      check("mem_reads", rd_cnt - r0, npix);
      check("done_gap", done_cyc - (bad ? start_cyc : last_pulse_cyc), exp_gap);
      check("latched_cfg", {img_width, img_height, padding_mode}, {w, h, pad});
   endtask

   // ---------------- stimulus ----------------
   int d0;
   int p0;
   initial begin
      bus.stall = 1'b0;
      bus.pool_valid = 2'b00;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;

      // 8x8 unpadded: Wc=Hc=6, EXP=4*4=16; done the cycle after the 16th pulse.
      run_frame(8'd8, 8'd8, PAD_NONE, 1'b0, 16, -1, -10, -10, {1'b0, ERR_OK, 16'd16}, 1);

      // 6x5 zero pad: EXP=4*3=12, 3-cycle stall and a start poke while busy.
      run_frame(8'd6, 8'd5, PAD_ZERO, 1'b0, 12, -1, 8, 4, {1'b0, ERR_OK, 16'd12}, 1);

      // 4x8 unpadded: Wc=2 is illegal; done two cycles after start.
      run_frame(8'd4, 8'd8, PAD_NONE, 1'b1, 0, -1, -10, -10, {1'b1, ERR_CFG, 16'd0}, 2);
      // start during FINISH must be ignored.
      cfg_width = 8'd8; cfg_height = 8'd8; cfg_padding = PAD_NONE;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("start_in_finish_ignored", busy, 1'b0);

      // Illegal padding code.
      run_frame(8'd8, 8'd8, PAD_ILLEGAL, 1'b1, 0, -1, -10, -10, {1'b1, ERR_CFG, 16'd0}, 2);

      // Lane 1 dropped once: lane error but the frame completes.
      run_frame(8'd8, 8'd8, PAD_NONE, 1'b0, 16, 5, -10, -10, {1'b1, ERR_LANE, 16'd16}, 1);

      // Only 5 of 16 outputs: timeout fires after TO idle cycles.
      run_frame(8'd8, 8'd8, PAD_NONE, 1'b0, 5, -1, -10, -10, {1'b1, ERR_TIMEOUT, 16'd5}, TO + 1);

      // Reset during STREAM: outputs clear next cycle, no done pulse.
      res_q.push_back('0);
      for (int i = 0; i < 64; i++) exp_q.push_back(pix_of(16'(i)));
      p0 = pix_seen;
      start_frame(8'd8, 8'd8, PAD_NONE);
      wait_pixels(p0 + 10, -10, -10, 100);
      @(negedge clk);
      rst_n = 1'b0;
      d0 = done_cnt;
      @(posedge clk);
      #1;
      check_reset_outputs("midframe_reset");
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      res_q.delete();
      repeat (4) @(negedge clk);
      check("no_done_after_reset", done_cnt, d0);

      // Normal frame after reset: 5x5 edge pad, Wc=Hc=5, EXP=3*3=9.
      run_frame(8'd5, 8'd5, PAD_EDGE, 1'b0, 9, -1, -10, -10, {1'b0, ERR_OK, 16'd9}, 1);

      repeat (3) @(negedge clk);
      check("pix_queue_empty", exp_q.size(), 0);
      check("result_queue_empty", res_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
